// File: rtl/sat_job_scheduler_pkg.sv
// Shared types for the SAT job scheduler: formula/literal types, job record and result status.
package sat_job_scheduler_pkg;

  typedef logic [7:0] lit;
  localparam int NUM_LITS = 4;
  localparam lit zero_lit = '0;
  typedef lit [NUM_LITS-1:0] formula;

  typedef enum logic [1:0] {
    RES_SAT     = 2'd0,
    RES_UNSAT   = 2'd1,
    RES_ERR     = 2'd2,
    RES_TIMEOUT = 2'd3
  } sched_status_t;

  typedef struct packed {
    formula     f;
    logic [3:0] id;
  } sched_job_t;

  // Exactly one verdict flag must be set; anything else is a kernel error.
  function automatic sched_status_t verdict(input logic sat, input logic unsat);
    if (sat && !unsat)      return RES_SAT;
    else if (unsat && !sat) return RES_UNSAT;
    else                    return RES_ERR;
  endfunction

endpackage

// File: rtl/sat_job_scheduler_fifo.sv
// Synchronous job FIFO for the scheduler; extra pointer bit distinguishes full from empty.
module sched_job_fifo
  import sat_job_scheduler_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       push,
  input  sched_job_t wdata,
  input  logic       pop,
  output sched_job_t rdata,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  sched_job_t     mem [DEPTH];
  logic [AW:0]    wr_ptr;
  logic [AW:0]    rd_ptr;

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/sat_job_scheduler.sv
// Runs queued SAT jobs one at a time on a single DB_kernel and returns verdict, model and cycle count.
// Optional RUN watchdog enabled by defining SAT_SCHED_TIMEOUT_EN.
//
//  state | meaning
//  IDLE  | waiting for a queued job; pops the FIFO head into the job register
//  LOAD  | one-cycle kernel reset, run counter cleared
//  RUN   | kernel searching (k_find=1), counter advancing
//  DONE  | result presented on res_*, waiting for res_ready
module sat_job_scheduler
  import sat_job_scheduler_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             job_valid,
  output logic             job_ready,
  input  formula           job_formula,
  input  logic [3:0]       job_id,
  output logic             k_reset,
  output logic             k_find,
  output formula           k_formula,
  input  logic             k_ended,
  input  logic             k_sat,
  input  logic             k_unsat,
  input  formula           k_out_formula,
  output logic             res_valid,
  input  logic             res_ready,
  output sched_status_t    res_status,
  output logic [3:0]       res_id,
  output formula           res_formula,
  output logic [CNT_W-1:0] res_cycles,
  output logic             busy
);

`ifdef SAT_SCHED_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  sched_job_t       job_q;
  sched_job_t       fifo_rdata;
  logic             fifo_full, fifo_empty;
  logic             fifo_pop;
  logic [CNT_W-1:0] cnt_q, cnt_inc;
  logic             to_hit;

  sched_job_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (job_valid && !fifo_full),
    .wdata ('{f: job_formula, id: job_id}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
  // A verdict arriving on the limit cycle takes priority over the watchdog.
  assign to_hit  = TO_EN && !k_ended && (cnt_inc == TO_LIM);

  always_comb begin
    state_d  = state_q;
    fifo_pop = 1'b0;
    k_find   = 1'b0;
    case (state_q)
      S_IDLE: if (!fifo_empty) begin
        fifo_pop = 1'b1;
        state_d  = S_LOAD;
      end
      S_LOAD: state_d = S_RUN;
      S_RUN: begin
        k_find = 1'b1;
        if (k_ended || to_hit) state_d = S_DONE;
      end
      S_DONE: if (res_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      job_q       <= '0;
      cnt_q       <= '0;
      res_status  <= RES_SAT;
      res_id      <= '0;
      res_formula <= '0;
      res_cycles  <= '0;
    end else begin
      state_q <= state_d;
      if (fifo_pop) job_q <= fifo_rdata;
      if (state_q == S_LOAD)     cnt_q <= '0;
      else if (state_q == S_RUN) cnt_q <= cnt_inc;
      if (state_q == S_RUN && k_ended) begin
        res_status  <= verdict(k_sat, k_unsat);
        res_id      <= job_q.id;
        res_formula <= k_out_formula;
        res_cycles  <= cnt_inc;
      end else if (state_q == S_RUN && to_hit) begin
        res_status  <= RES_TIMEOUT;
        res_id      <= job_q.id;
        res_formula <= {NUM_LITS{zero_lit}};
        res_cycles  <= TO_LIM;
      end
    end
  end

  assign job_ready = !fifo_full;
  assign k_reset   = reset || (state_q == S_LOAD);
  assign k_formula = job_q.f;
  assign res_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_sat_job_scheduler.sv
// Scoreboard bench for sat_job_scheduler with a behavioural DB_kernel model driven per job id.
module tb_sat_job_scheduler;
  import sat_job_scheduler_pkg::*;

  localparam int CW = 5;

  logic          clock = 1'b0;
  logic          reset;
  logic          job_valid;
  logic          job_ready;
  formula        job_formula;
  logic [3:0]    job_id;
  logic          k_reset, k_find;
  formula        k_formula;
  logic          k_ended = 1'b0, k_sat = 1'b0, k_unsat = 1'b0;
  formula        k_out_formula = '0;
  logic          res_valid;
  logic          res_ready;
  sched_status_t res_status;
  logic [3:0]    res_id;
  formula        res_formula;
  logic [CW-1:0] res_cycles;
  logic          busy;

  sat_job_scheduler #(.DEPTH(4), .CNT_W(CW), .TIMEOUT(20)) dut (
    .clock(clock), .reset(reset),
    .job_valid(job_valid), .job_ready(job_ready), .job_formula(job_formula), .job_id(job_id),
    .k_reset(k_reset), .k_find(k_find), .k_formula(k_formula),
    .k_ended(k_ended), .k_sat(k_sat), .k_unsat(k_unsat), .k_out_formula(k_out_formula),
    .res_valid(res_valid), .res_ready(res_ready), .res_status(res_status), .res_id(res_id),
    .res_formula(res_formula), .res_cycles(res_cycles), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    sched_status_t st;
    logic [3:0]    id;
    formula        f;
    logic [CW-1:0] cyc;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic formula mkf(input logic [3:0] id);
    return {4'hA, id, 8'h5A, 4'h3, id, 4'h0, id};
  endfunction

  // Kernel model: per-id run length (0 = never ends) and verdict flags.
  int         cfg_len [16];
  bit         cfg_sat [16];
  bit         cfg_unsat [16];
  int         rc = 0;
  logic [3:0] kix;

  always @(negedge clock) begin
    kix = k_formula[3:0];
    if (k_reset) rc = 0;
    else if (k_find) rc++;
    k_ended       = k_find && !k_reset && (cfg_len[kix] != 0) && (rc == cfg_len[kix]);
    k_sat         = cfg_sat[kix];
    k_unsat       = cfg_unsat[kix];
    k_out_formula = ~k_formula;
  end

  // Result monitor: compares each accepted result against the scoreboard head.
  always @(negedge clock) begin
    #1;
    if (res_valid && res_ready) begin
      if (sb.size() == 0) chk("unexpected_result", {60'd0, res_id}, 64'hFFFF);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("res_id", res_id, e.id);
        chk("res_status", res_status, e.st);
        chk("res_formula", res_formula, e.f);
        chk("res_cycles", res_cycles, e.cyc);
      end
    end
  end

  // Every non-reset k_reset pulse must last exactly one cycle.
  int kr_len = 0;
  always @(negedge clock) begin
    #1;
    if (k_reset && !reset) kr_len++;
    else if (kr_len != 0) begin
      chk("k_reset_pulse_len", kr_len, 1);
      kr_len = 0;
    end
  end

  task automatic enq(input logic [3:0] id, input int len, input bit sat, input bit unsat,
                     input bit expect_res);
    int   n = 0;
    exp_t e;
    cfg_len[id] = len; cfg_sat[id] = sat; cfg_unsat[id] = unsat;
    job_valid = 1'b1; job_formula = mkf(id); job_id = id;
    while (!job_ready && n < 300) begin @(negedge clock); n++; end
    if (n >= 300) chk("enq_timeout", 1, 0);
    if (expect_res) begin
      e.id = id; e.f = ~mkf(id); e.cyc = CW'(len);
      e.st = verdict(sat, unsat);
      sb.push_back(e);
    end
    @(negedge clock);
    job_valid = 1'b0;
  endtask

  task automatic push_exp(input sched_status_t st, input logic [3:0] id, input formula f,
                          input logic [CW-1:0] cyc);
    exp_t e;
    e.st = st; e.id = id; e.f = f; e.cyc = cyc;
    sb.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 2000) begin @(negedge clock); n++; end
    chk("drain_timeout", n < 2000, 1);
  endtask

  task automatic wait_find();
    int n = 0;
    while (!k_find && n < 200) begin @(negedge clock); n++; end
    chk("wait_find_timeout", n < 200, 1);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin cfg_len[i] = 0; cfg_sat[i] = 0; cfg_unsat[i] = 0; end
    reset = 1'b1; job_valid = 1'b0; job_formula = '0; job_id = '0; res_ready = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_k_reset", k_reset, 1);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_busy", busy, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_job_ready", job_ready, 1);
    chk("rst_k_find", k_find, 0);
    chk("rst_k_reset_low", k_reset, 0);
    chk("rst_k_formula", k_formula, 0);
    chk("rst_res_fields", {res_status, res_id, res_formula, res_cycles}, 0);

    // Single job: ended+sat in 5th RUN cycle; check enqueue-to-find latency.
    res_ready = 1'b1;
    enq(4'd1, 5, 1, 0, 1);
    chk("lat_find_early", k_find, 0);
    @(negedge clock);
    chk("lat_load_k_reset", k_reset, 1);
    chk("lat_load_busy", busy, 1);
    @(negedge clock);
    chk("lat_run_k_find", k_find, 1);
    chk("run_k_formula", k_formula, mkf(4'd1));
    drain();

    // Fill FIFO behind a running job; extra job must stall, results in order.
    for (int i = 1; i <= 5; i++) enq(4'(i), 8, (i % 2) == 1, (i % 2) == 0, 1);
    chk("full_job_ready", job_ready, 0);
    repeat (3) @(negedge clock);
    chk("full_job_ready_hold", job_ready, 0);
    enq(4'd6, 3, 0, 1, 1);
    drain();

    // Result held in DONE while the host stalls.
    res_ready = 1'b0;
    enq(4'd7, 4, 0, 1, 1);
    enq(4'd8, 2, 1, 0, 1);
    begin
      int n = 0;
      while (!res_valid && n < 100) begin @(negedge clock); n++; end
      chk("done_wait_timeout", n < 100, 1);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk("hold_res", {res_valid, k_find, k_reset, res_id, res_status, res_cycles},
          {1'b1, 1'b0, 1'b0, 4'd7, RES_UNSAT, CW'(4)});
    end
    res_ready = 1'b1;
    drain();

    // Malformed verdicts: both flags, then neither.
    enq(4'd9, 3, 1, 1, 1);
    enq(4'd10, 2, 0, 0, 1);
    drain();

    // Reset while running with two jobs queued: everything discarded.
    enq(4'd11, 0, 1, 0, 0);
    enq(4'd12, 3, 1, 0, 0);
    enq(4'd13, 3, 1, 0, 0);
    wait_find();
    reset = 1'b1;
    #1 chk("midrst_k_reset_comb", k_reset, 1);
    @(negedge clock);
    reset = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_res_valid", res_valid, 0);
    chk("midrst_k_find", k_find, 0);
    chk("midrst_job_ready", job_ready, 1);
    repeat (8) @(negedge clock);
    chk("midrst_fifo_empty", {busy, k_reset, res_valid}, 0);

`ifdef SAT_SCHED_TIMEOUT_EN
    enq(4'd14, 0, 1, 0, 0);
    push_exp(RES_TIMEOUT, 4'd14, '0, CW'(20));
    enq(4'd15, 20, 1, 0, 1);
    enq(4'd3, 21, 0, 1, 0);
    push_exp(RES_TIMEOUT, 4'd3, '0, CW'(20));
    drain();
`else
    // No watchdog: a long run is not cut off and its count saturates.
    enq(4'd14, 40, 1, 0, 0);
    push_exp(RES_SAT, 4'd14, ~mkf(4'd14), {CW{1'b1}});
    wait_find();
    repeat (25) @(negedge clock);
    chk("no_wd_still_running", {k_find, res_valid}, 2'b10);
    drain();
`endif

    chk("sb_empty_at_end", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
